// File: rtl/line_capture_pkg.sv
// Shared types for the stroke capture stage.
// Coordinate widths, FSM states and saturating counter helper.
package line_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DRAW,
    PLACE
  } capture_state_t;

  typedef logic [10:0] xcoord_t;
  typedef logic [9:0]  ycoord_t;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/coord_abs_diff.sv
// Unsigned absolute difference of two 12-bit coordinates.
module coord_abs_diff (
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic [11:0] d_o
);

  assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/line_stroke_capture.sv
// Marker centroid to line segment capture: debounce, latch, jitter filter,
// minimum-length commit with a one-cycle place pulse.
module line_stroke_capture
  import line_capture_pkg::*;
#(
  parameter int H_ACTIVE       = 1280,
  parameter int V_ACTIVE       = 720,
  parameter int ARM_FRAMES     = 3,
  parameter int RELEASE_FRAMES = 4,
  parameter int JITTER         = 2,
  parameter int MIN_LEN        = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        present_in,
  input  logic        valid_in,
  input  logic        abort_in,
  output logic [10:0] line_x1_out,
  output logic [9:0]  line_y1_out,
  output logic [10:0] line_x2_out,
  output logic [9:0]  line_y2_out,
  output logic        place_out,
  output logic        drawing_out
);

  localparam xcoord_t     H_LIM = xcoord_t'(H_ACTIVE);
  localparam ycoord_t     V_LIM = ycoord_t'(V_ACTIVE);
  localparam cnt_t        ARM_N = cnt_t'(ARM_FRAMES);
  localparam cnt_t        REL_N = cnt_t'(RELEASE_FRAMES);
  localparam logic [11:0] JIT   = 12'(JITTER);
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);

  capture_state_t state_q;
  cnt_t           cnt_q;
  cnt_t           miss_q;
  xcoord_t        x1_q, x2_q;
  ycoord_t        y1_q, y2_q;
  logic           place_q;
  logic           drawing_q;

  logic [11:0] dx, dy, lx, ly, len;
  logic        pres, moved;
  cnt_t        cnt_inc, miss_inc;

  coord_abs_diff u_dx (
    .a_i({1'b0, x_in}),
    .b_i({1'b0, x2_q}),
    .d_o(dx)
  );

  coord_abs_diff u_dy (
    .a_i({2'b0, y_in}),
    .b_i({2'b0, y2_q}),
    .d_o(dy)
  );

  coord_abs_diff u_lx (
    .a_i({1'b0, x2_q}),
    .b_i({1'b0, x1_q}),
    .d_o(lx)
  );

  coord_abs_diff u_ly (
    .a_i({2'b0, y2_q}),
    .b_i({2'b0, y1_q}),
    .d_o(ly)
  );

  assign len      = lx + ly;
  assign pres     = present_in && (x_in < H_LIM) && (y_in < V_LIM);
  assign moved    = (dx > JIT) || (dy > JIT);
  assign cnt_inc  = sat_inc(cnt_q);
  assign miss_inc = sat_inc(miss_q);

  // The sample that completes arming is the latest start, so it seeds both ends.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      miss_q    <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      place_q   <= 1'b0;
      drawing_q <= 1'b0;
    end else begin
      place_q <= 1'b0;
      if (abort_in) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        miss_q    <= '0;
        drawing_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (valid_in && pres) begin
              cnt_q <= cnt_t'(1);
              if (ARM_N <= cnt_t'(1)) begin
                state_q   <= DRAW;
                drawing_q <= 1'b1;
                miss_q    <= '0;
                x1_q      <= x_in;
                x2_q      <= x_in;
                y1_q      <= y_in;
                y2_q      <= y_in;
              end else begin
                state_q <= ARM;
              end
            end
          end
          ARM: begin
            if (valid_in) begin
              if (pres) begin
                cnt_q <= cnt_inc;
                if (cnt_inc >= ARM_N) begin
                  state_q   <= DRAW;
                  drawing_q <= 1'b1;
                  miss_q    <= '0;
                  x1_q      <= x_in;
                  x2_q      <= x_in;
                  y1_q      <= y_in;
                  y2_q      <= y_in;
                end
              end else begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end
            end
          end
          DRAW: begin
            if (valid_in) begin
              if (pres) begin
                miss_q <= '0;
                if (moved) begin
                  x2_q <= x_in;
                  y2_q <= y_in;
                end
              end else begin
                miss_q <= miss_inc;
                if (miss_inc >= REL_N) begin
                  drawing_q <= 1'b0;
                  cnt_q     <= '0;
                  miss_q    <= '0;
                  if (len >= MIN_L) begin
                    state_q <= PLACE;
                    place_q <= 1'b1;
                  end else begin
                    state_q <= IDLE;
                  end
                end
              end
            end
          end
          PLACE: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign line_x1_out = x1_q;
  assign line_y1_out = y1_q;
  assign line_x2_out = x2_q;
  assign line_y2_out = y2_q;
  assign place_out   = place_q;
  assign drawing_out = drawing_q;

endmodule

// File: tb/tb_line_stroke_capture.sv
// Directed bench for line_stroke_capture: arming, release, jitter,
// short-stroke discard, abort, off-screen samples and async reset.
module tb_line_stroke_capture;

  logic        clk;
  logic        rst_n;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        present;
  logic        valid;
  logic        abort;
  logic [10:0] x1, x2;
  logic [9:0]  y1, y2;
  logic        place;
  logic        drawing;

  int n_assert = 0;
  int n_fail   = 0;
  int place_cnt = 0;
  int base;

  line_stroke_capture dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .x_in       (x_in),
    .y_in       (y_in),
    .present_in (present),
    .valid_in   (valid),
    .abort_in   (abort),
    .line_x1_out(x1),
    .line_y1_out(y1),
    .line_x2_out(x2),
    .line_y2_out(y2),
    .place_out  (place),
    .drawing_out(drawing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (place === 1'b1) place_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input int ex1, input int ey1,
                          input int ex2, input int ey2);
    chk({tag, ".x1"}, int'(x1), ex1);
    chk({tag, ".y1"}, int'(y1), ey1);
    chk({tag, ".x2"}, int'(x2), ex2);
    chk({tag, ".y2"}, int'(y2), ey2);
  endtask

  task automatic frame(input int x, input int y, input bit p);
    @(negedge clk);
    x_in    = 11'(x);
    y_in    = 10'(y);
    present = p;
    valid   = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
    present = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; x_in = '0; y_in = '0;
    present = 1'b0; valid = 1'b0; abort = 1'b0;
    idle(3);
    chk("rst.place", int'(place), 0);
    chk("rst.drawing", int'(drawing), 0);
    chk_line("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(2);

    // 1: arm at (100,200), drag to (400,200), release
    base = place_cnt;
    frame(100, 200, 1'b1);
    chk("t1.arm1", int'(drawing), 0);
    frame(100, 200, 1'b1);
    chk("t1.arm2", int'(drawing), 0);
    frame(100, 200, 1'b1);
    chk("t1.arm3", int'(drawing), 1);
    chk_line("t1.entry", 100, 200, 100, 200);
    for (int i = 1; i <= 5; i++) frame(100 + 60 * i, 200, 1'b1);
    chk_line("t1.moved", 100, 200, 400, 200);
    for (int i = 0; i < 3; i++) frame(0, 0, 1'b0);
    chk("t1.miss3.drawing", int'(drawing), 1);
    chk("t1.miss3.place", int'(place), 0);
    frame(0, 0, 1'b0);
    chk("t1.place.latency", int'(place), 1);
    chk("t1.place.drawing", int'(drawing), 0);
    idle(1);
    chk("t1.place.width", int'(place), 0);
    idle(2);
    chk("t1.place.count", place_cnt - base, 1);
    chk_line("t1.commit", 100, 200, 400, 200);

    // 2: two present frames, then absent, then one more present
    base = place_cnt;
    frame(10, 10, 1'b1);
    frame(10, 10, 1'b1);
    frame(0, 0, 1'b0);
    frame(10, 10, 1'b1);
    chk("t2.no_draw", int'(drawing), 0);
    frame(0, 0, 1'b0);
    idle(2);
    chk("t2.no_place", place_cnt - base, 0);
    chk_line("t2.hold", 100, 200, 400, 200);

    // 3: jitter rejection at (300,300)
    for (int i = 0; i < 3; i++) frame(300, 300, 1'b1);
    chk("t3.drawing", int'(drawing), 1);
    frame(302, 301, 1'b1);
    chk_line("t3.jitter", 300, 300, 300, 300);
    frame(303, 300, 1'b1);
    chk_line("t3.move", 300, 300, 303, 300);

    // 5a: abort with valid in the same cycle
    base = place_cnt;
    @(negedge clk);
    x_in = 11'd500; y_in = 10'd500; present = 1'b1;
    valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    valid = 1'b0; abort = 1'b0; present = 1'b0;
    chk("t5.abort.drawing", int'(drawing), 0);
    chk_line("t5.abort.hold", 300, 300, 303, 300);
    frame(500, 500, 1'b1);
    chk("t5.abort.idle", int'(drawing), 0);
    frame(0, 0, 1'b0);
    idle(2);
    chk("t5.abort.no_place", place_cnt - base, 0);

    // 4: short stroke (50,50)-(55,58), length 13, discarded
    base = place_cnt;
    for (int i = 0; i < 3; i++) frame(50, 50, 1'b1);
    frame(55, 58, 1'b1);
    chk_line("t4.open", 50, 50, 55, 58);
    for (int i = 0; i < 4; i++) frame(0, 0, 1'b0);
    chk("t4.drawing", int'(drawing), 0);
    chk("t4.place", int'(place), 0);
    idle(2);
    chk("t4.no_place", place_cnt - base, 0);
    chk_line("t4.hold", 50, 50, 55, 58);

    // 5b: off-screen samples release an open stroke
    base = place_cnt;
    for (int i = 0; i < 3; i++) frame(600, 100, 1'b1);
    frame(600, 140, 1'b1);
    frame(1300, 140, 1'b1);
    frame(1300, 140, 1'b1);
    frame(600, 720, 1'b1);
    chk("t5.offscreen.drawing", int'(drawing), 1);
    frame(1300, 100, 1'b1);
    chk("t5.offscreen.place", int'(place), 1);
    idle(2);
    chk("t5.offscreen.count", place_cnt - base, 1);
    chk_line("t5.offscreen", 600, 100, 600, 140);

    // 6: async reset mid-DRAW
    for (int i = 0; i < 3; i++) frame(200, 200, 1'b1);
    chk("t6.drawing", int'(drawing), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6.rst.drawing", int'(drawing), 0);
    chk("t6.rst.place", int'(place), 0);
    chk_line("t6.rst", 0, 0, 0, 0);
    idle(2);
    #2 rst_n = 1'b1;
    frame(200, 200, 1'b1);
    chk("t6.after.idle", int'(drawing), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
